// File: rtl/nn_stream_if.sv
// Byte-stream handshake bundle feeding nn_stream_loader.
// valid/ready with a last flag on the final byte of each frame.
interface nn_stream_if #(
    parameter int unsigned DW = 8
) ();
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/nn_stream_loader.sv
// Assembles command-prefixed parameter/input frames into shadow storage and commits them
// atomically to the fully connected layer's parallel weight, bias and input buses.
module nn_stream_loader #(
    parameter int unsigned   DW        = 8,
    parameter int unsigned   N_IN      = 10,
    parameter int unsigned   N_OUT     = 10,
    parameter logic [DW-1:0] CMD_PARAM = 8'h01,
    parameter logic [DW-1:0] CMD_INPUT = 8'h02
) (
    input  logic          clk,
    input  logic          reset,
    nn_stream_if.slave    strm,
    output logic [DW-1:0] inputs_o  [0:N_IN-1],
    output logic [DW-1:0] weights_o [N_OUT*N_IN-1:0],
    output logic [DW-1:0] biases_o  [0:N_OUT-1],
    output logic          params_loaded,
    output logic          vec_valid,
    output logic          frame_err
);
    localparam int unsigned NW   = N_OUT * N_IN;
    localparam int unsigned PLen = NW + N_OUT;
    localparam int unsigned CW   = $clog2(PLen + 1);
    localparam logic [CW-1:0] PLenC = CW'(PLen);
    localparam logic [CW-1:0] ILenC = CW'(N_IN);

    typedef enum logic [1:0] {StIdle, StLoad, StDrain, StCommit} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc, len;
    logic          is_param_q, is_param_d;
    logic          err_d, wr_en, beat;
    logic [DW-1:0] shadow_q [PLen];

    assign strm.s_ready = (state_q != StCommit);
    assign beat         = strm.s_valid && strm.s_ready;
    assign cnt_inc      = cnt_q + CW'(1);
    assign len          = is_param_q ? PLenC : ILenC;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_param_d = is_param_q;
        err_d      = 1'b0;
        wr_en      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (beat) begin
                    if (strm.s_last) begin
                        err_d = 1'b1;
                    end else if (strm.s_data == CMD_PARAM || strm.s_data == CMD_INPUT) begin
                        state_d    = StLoad;
                        is_param_d = (strm.s_data == CMD_PARAM);
                        cnt_d      = '0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StDrain;
                    end
                end
            end
            StLoad: begin
                if (beat) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_inc;
                    if (cnt_inc == len) begin
                        if (strm.s_last) begin
                            state_d = StCommit;
                        end else begin
                            err_d   = 1'b1;
                            state_d = StDrain;
                        end
                    end else if (strm.s_last) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StDrain: begin
                if (beat && strm.s_last) begin
                    state_d = StIdle;
                end
            end
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            is_param_q <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_param_q <= is_param_d;
            frame_err  <= err_d;
        end
    end

    // Shadow contents are only meaningful once a full frame has landed, so no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            shadow_q[cnt_q] <= strm.s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < N_IN; j++) inputs_o[j] <= '0;
            for (int k = 0; k < NW; k++) weights_o[k] <= '0;
            for (int i = 0; i < N_OUT; i++) biases_o[i] <= '0;
            params_loaded <= 1'b0;
            vec_valid     <= 1'b0;
        end else begin
            vec_valid <= 1'b0;
            if (state_q == StCommit) begin
                if (is_param_q) begin
                    for (int k = 0; k < NW; k++) weights_o[k] <= shadow_q[k];
                    for (int i = 0; i < N_OUT; i++) biases_o[i] <= shadow_q[NW+i];
                    params_loaded <= 1'b1;
                end else begin
                    for (int j = 0; j < N_IN; j++) inputs_o[j] <= shadow_q[j];
                    vec_valid <= params_loaded;
                end
            end
        end
    end
endmodule

// File: tb/tb_nn_stream_loader.sv
// Directed bench for nn_stream_loader: frame commits, latency, malformed frames, gaps, reset.
module tb_nn_stream_loader;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nn_stream_if #(.DW(8)) strm ();

    logic [7:0] inputs_o  [0:9];
    logic [7:0] weights_o [99:0];
    logic [7:0] biases_o  [0:9];
    logic       params_loaded, vec_valid, frame_err;

    nn_stream_loader dut (
        .clk           (clk),
        .reset         (reset),
        .strm          (strm),
        .inputs_o      (inputs_o),
        .weights_o     (weights_o),
        .biases_o      (biases_o),
        .params_loaded (params_loaded),
        .vec_valid     (vec_valid),
        .frame_err     (frame_err)
    );

    int errors = 0;
    int checks = 0;
    int err_cnt = 0, vv_cnt = 0, both_cnt = 0;
    int e0, v0;

    always @(negedge clk) begin
        if (frame_err) err_cnt++;
        if (vec_valid) vv_cnt++;
        if (frame_err && vec_valid) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, input int gap);
        int n;
        repeat (gap) begin
            @(negedge clk);
            strm.s_valid = 1'b0;
        end
        @(negedge clk);
        strm.s_valid = 1'b1;
        strm.s_data  = d;
        strm.s_last  = l;
        n = 0;
        while (!strm.s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 0, 1);
        @(posedge clk);
    endtask

    task automatic end_frame();
        @(negedge clk);
        strm.s_valid = 1'b0;
        strm.s_last  = 1'b0;
    endtask

    // Payload byte i is base+i, except param bias bytes which are 200+neuron.
    task automatic send_frame(input logic [7:0] cmd, input int n, input int base,
                              input bit with_last, input bit gaps);
        logic [7:0] v;
        send_byte(cmd, 1'b0, gaps ? int'($urandom_range(0, 3)) : 0);
        for (int i = 0; i < n; i++) begin
            v = (cmd == 8'h01 && i >= 100) ? 8'(200 + i - 100) : 8'(base + i);
            send_byte(v, with_last && (i == n - 1), gaps ? int'($urandom_range(0, 3)) : 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        strm.s_valid = 1'b0;
        strm.s_last  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        strm.s_valid = 1'b0;
        strm.s_data  = 8'h00;
        strm.s_last  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_params_loaded", params_loaded, 0);
        check("rst_weights5", weights_o[5], 0);
        check("rst_inputs0", inputs_o[0], 0);
        check("rst_vec_valid", vec_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_ready", strm.s_ready, 1);

        // T1: parameter frame
        send_frame(8'h01, 110, 0, 1'b1, 1'b0);
        end_frame();
        check("t1_commit_cycle_ready", strm.s_ready, 0);
        check("t1_not_yet_loaded", params_loaded, 0);
        @(negedge clk);
        check("t1_w37", weights_o[37], 37);
        check("t1_w99", weights_o[99], 99);
        check("t1_b0", biases_o[0], 200);
        check("t1_b9", biases_o[9], 209);
        check("t1_params_loaded", params_loaded, 1);
        check("t1_vec_valid", vec_valid, 0);
        check("t1_inputs_untouched", inputs_o[3], 0);

        // T2: input frame 1..10 with params loaded
        v0 = vv_cnt;
        send_frame(8'h02, 10, 1, 1'b1, 1'b0);
        end_frame();
        check("t2_vv_early", vec_valid, 0);
        check("t2_in0_old", inputs_o[0], 0);
        @(negedge clk);
        check("t2_vec_valid", vec_valid, 1);
        check("t2_in0", inputs_o[0], 1);
        check("t2_in9", inputs_o[9], 10);
        check("t2_w37_kept", weights_o[37], 37);
        @(negedge clk);
        check("t2_vv_drop", vec_valid, 0);
        repeat (2) @(negedge clk);
        check("t2_vv_pulses", vv_cnt - v0, 1);

        // T3: short then long input frame
        e0 = err_cnt;
        v0 = vv_cnt;
        send_frame(8'h02, 7, 50, 1'b1, 1'b0);
        end_frame();
        check("t3_short_err", frame_err, 1);
        @(negedge clk);
        check("t3_short_err_drop", frame_err, 0);
        check("t3_short_in0", inputs_o[0], 1);
        check("t3_short_in6", inputs_o[6], 7);
        send_frame(8'h02, 12, 80, 1'b1, 1'b0);
        end_frame();
        repeat (3) @(negedge clk);
        check("t3_err_pulses", err_cnt - e0, 2);
        check("t3_long_in6", inputs_o[6], 7);
        check("t3_no_vv", vv_cnt - v0, 0);

        // T4: unknown command, command-only frame, then recovery
        e0 = err_cnt;
        send_frame(8'h55, 5, 0, 1'b1, 1'b0);
        end_frame();
        repeat (2) @(negedge clk);
        check("t4_bad_cmd_err", err_cnt - e0, 1);
        send_byte(8'h02, 1'b1, 0);
        end_frame();
        check("t4_cmd_only_err", frame_err, 1);
        send_frame(8'h02, 10, 11, 1'b1, 1'b0);
        end_frame();
        @(negedge clk);
        check("t4_vec_valid", vec_valid, 1);
        check("t4_in0", inputs_o[0], 11);
        check("t4_in9", inputs_o[9], 20);
        check("t4_b9_kept", biases_o[9], 209);

        // T5: input frames after reset, gapless and gapped
        do_reset();
        v0 = vv_cnt;
        send_frame(8'h02, 10, 30, 1'b1, 1'b0);
        end_frame();
        @(negedge clk);
        check("t5_vec_valid", vec_valid, 0);
        check("t5_in0", inputs_o[0], 30);
        check("t5_params_loaded", params_loaded, 0);
        check("t5_w37", weights_o[37], 0);
        send_frame(8'h02, 10, 40, 1'b1, 1'b1);
        end_frame();
        @(negedge clk);
        check("t5_gap_in0", inputs_o[0], 40);
        check("t5_gap_in9", inputs_o[9], 49);
        repeat (2) @(negedge clk);
        check("t5_no_vv", vv_cnt - v0, 0);

        // T6: reset in the middle of a parameter frame
        send_frame(8'h01, 110, 0, 1'b1, 1'b0);
        end_frame();
        @(negedge clk);
        check("t6_pre_loaded", params_loaded, 1);
        send_frame(8'h01, 50, 0, 1'b0, 1'b0);
        do_reset();
        check("t6_w37", weights_o[37], 0);
        check("t6_b9", biases_o[9], 0);
        check("t6_params_loaded", params_loaded, 0);
        check("t6_in0", inputs_o[0], 0);
        v0 = vv_cnt;
        send_frame(8'h02, 10, 60, 1'b1, 1'b0);
        end_frame();
        @(negedge clk);
        check("t6_in0_new", inputs_o[0], 60);
        check("t6_vec_valid", vec_valid, 0);
        repeat (2) @(negedge clk);
        check("t6_no_vv", vv_cnt - v0, 0);
        check("never_both", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
